// File: rtl/minterm_enumerator.sv
// Streams every index x of a captured truth table whose bit equals the requested polarity, in ascending order.
// Latency: start is sampled in cycle 0. One cycle per scanned index, plus one per emitted term, plus one DONE cycle.
// Backpressure: while x_ready is low, the current term is held in EMIT with x_out and x_last stable.
module minterm_enumerator #(
    parameter int N_IN = 4
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 start,
    input  logic [(1<<N_IN)-1:0] table_in,
    input  logic                 polarity,
    output logic                 busy,
    output logic                 x_valid,
    input  logic                 x_ready,
    output logic [N_IN-1:0]      x_out,
    output logic                 x_last,
    output logic                 done,
    output logic [N_IN:0]        count
);
    localparam int W = 1 << N_IN;

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    state_t          state, state_nxt;
    logic [N_IN-1:0] idx, idx_nxt;
    logic [W-1:0]    tbl, tbl_nxt;
    logic            pol, pol_nxt;
    logic [N_IN:0]   cnt, cnt_nxt;
    logic [W-1:0]    m, rem, above;

    // rem drives early exit in SCAN; above drives x_last in EMIT.
    // Together they keep idx from ever stepping past the top index.
    assign m     = pol ? tbl : ~tbl;
    assign rem   = m & ({W{1'b1}} << idx);
    assign above = m & (({W{1'b1}} << idx) << 1);

    assign busy    = (state == SCAN) || (state == EMIT);
    assign x_valid = (state == EMIT);
    assign x_out   = idx;
    assign x_last  = (state == EMIT) && (above == '0);
    assign done    = (state == DONE);
    assign count   = cnt;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tbl_nxt   = tbl;
        pol_nxt   = pol;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    tbl_nxt   = table_in;
                    pol_nxt   = polarity;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (rem == '0) begin
                    state_nxt = DONE;
                end else if (m[idx]) begin
                    state_nxt = EMIT;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            EMIT: begin
                if (x_ready) begin
                    cnt_nxt = cnt + 1'b1;
                    if (x_last) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = SCAN;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            idx   <= '0;
            tbl   <= '0;
            pol   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            tbl   <= tbl_nxt;
            pol   <= pol_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule
